// File: rtl/sram_ctrl_ws.sv
// sram_ctrl_ws: async-SRAM controller with configurable read/write wait states, byte lanes and chip-select gating.
// Optional feature macro SRAM_TURNAROUND_EN: inserts one dead cycle when a write directly follows a read.
module sram_ctrl_ws #(
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic                  i_CLK,
    input  logic                  i_Reset,
    input  logic                  i_Begin,
    input  logic                  i_Write,
    input  logic [ADDR_W-1:0]     i_Addr,
    input  logic [DATA_W/8-1:0]   i_BE,
    input  logic [DATA_W-1:0]     i_Data_f2s,
    output logic [DATA_W-1:0]     o_Data_s2f,
    output logic                  o_RdValid,
    output logic                  o_Ready,
    output logic                  o_CS_N,
    output logic                  o_OE_N,
    output logic                  o_WE_N,
    output logic [DATA_W/8-1:0]   o_BE_N,
    output logic [ADDR_W-1:0]     o_Addr,
    inout  wire  [DATA_W-1:0]     io_IO
);
    localparam int BE_W     = DATA_W / 8;
    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

    if (RD_WAIT < 1) begin : g_bad_rd_wait
        $error("sram_ctrl_ws: RD_WAIT must be at least 1");
    end
    if (WR_WAIT < 1) begin : g_bad_wr_wait
        $error("sram_ctrl_ws: WR_WAIT must be at least 1");
    end
    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
        $error("sram_ctrl_ws: DATA_W must be a non-zero multiple of 8");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RD_ACCESS,
        ST_RD_END
`ifdef SRAM_TURNAROUND_EN
        , ST_TURN
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wrData_q;
    logic [DATA_W-1:0]   rdData_q;
    logic [DATA_W-1:0]   laneMask;
    logic                rdValid_q;
    logic                ready_q;
    logic                drive_q;
    logic                csN_q, oeN_q, weN_q;
    logic [BE_W-1:0]     beN_q;
    logic                accept;
    logic                nextWrite, nextRead;

    assign accept    = i_Begin && ready_q;
    assign be_d      = accept ? i_BE : be_q;
    assign nextWrite = (state_d == ST_WR_PULSE) || (state_d == ST_WR_HOLD);
    assign nextRead  = (state_d == ST_RD_ACCESS) || (state_d == ST_RD_END);

    // Next-state and wait-counter logic; the counter is loaded with WAIT-1 on entry and exits at zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_WR_HOLD: begin
                if (accept) begin
                    state_d = i_Write ? ST_WR_PULSE : ST_RD_ACCESS;
                    cnt_d   = i_Write ? WR_LOAD : RD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_END: begin
                if (accept && i_Write) begin
`ifdef SRAM_TURNAROUND_EN
                    state_d = ST_TURN;
`else
                    state_d = ST_WR_PULSE;
`endif
                    cnt_d   = WR_LOAD;
                end else if (accept) begin
                    state_d = ST_RD_ACCESS;
                    cnt_d   = RD_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_PULSE: begin
                if (cnt_q == '0) state_d = ST_WR_HOLD;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_RD_ACCESS: begin
                if (cnt_q == '0) state_d = ST_RD_END;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
`ifdef SRAM_TURNAROUND_EN
            ST_TURN: state_d = ST_WR_PULSE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data is masked per lane so that disabled lanes always load zero.
    always_comb begin
        laneMask = '0;
        for (int b = 0; b < BE_W; b++) begin
            laneMask[b*8 +: 8] = {8{be_q[b]}};
        end
    end

    // All pin-facing outputs are registered from the next state, so nothing on i_* reaches the SRAM pins combinationally.
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            wrData_q  <= '0;
            rdData_q  <= '0;
            rdValid_q <= 1'b0;
            ready_q   <= 1'b1;
            drive_q   <= 1'b0;
            csN_q     <= 1'b1;
            oeN_q     <= 1'b1;
            weN_q     <= 1'b1;
            beN_q     <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= i_Addr;
                be_q   <= i_BE;
                if (i_Write) begin
                    wrData_q <= i_Data_f2s;
                end
            end
            csN_q     <= !(nextWrite || nextRead);
            oeN_q     <= !nextRead;
            weN_q     <= (state_d != ST_WR_PULSE);
            beN_q     <= (nextWrite || nextRead) ? ~be_d : '1;
            drive_q   <= nextWrite;
            ready_q   <= (state_d == ST_IDLE) || (state_d == ST_WR_HOLD) || (state_d == ST_RD_END);
            rdValid_q <= (state_q == ST_RD_END);
            if (state_q == ST_RD_END) begin
                rdData_q <= io_IO & laneMask;
            end
        end
    end

    assign io_IO      = drive_q ? wrData_q : {DATA_W{1'bz}};
    assign o_Ready    = ready_q && !i_Reset;
    assign o_RdValid  = rdValid_q;
    assign o_Data_s2f = rdData_q;
    assign o_CS_N     = csN_q;
    assign o_OE_N     = oeN_q;
    assign o_WE_N     = weN_q;
    assign o_BE_N     = beN_q;
    assign o_Addr     = addr_q;

endmodule

// File: tb/tb_sram_ctrl_ws.sv
// Testbench for sram_ctrl_ws (RD_WAIT=2, WR_WAIT=3): directed vector table, back-to-back sequence and randomized run.
// Honours SRAM_TURNAROUND_EN when computing expected turnaround timing.
module tb_sram_ctrl_ws;
    localparam int ADDR_W  = 19;
    localparam int DATA_W  = 16;
    localparam int BE_W    = 2;
    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 3;
`ifdef SRAM_TURNAROUND_EN
    localparam int TURN = 1;
`else
    localparam int TURN = 0;
`endif

    logic              clk;
    logic              iReset, iBegin, iWrite;
    logic [ADDR_W-1:0] iAddr;
    logic [BE_W-1:0]   iBE;
    logic [DATA_W-1:0] iData;
    logic [DATA_W-1:0] oData;
    logic              oRdValid, oReady, oCsN, oOeN, oWeN;
    logic [BE_W-1:0]   oBeN;
    logic [ADDR_W-1:0] oAddr;
    wire  [DATA_W-1:0] sramBus;

    int vectors = 0;
    int miscompares = 0;

    sram_ctrl_ws #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .i_CLK(clk), .i_Reset(iReset), .i_Begin(iBegin), .i_Write(iWrite),
        .i_Addr(iAddr), .i_BE(iBE), .i_Data_f2s(iData),
        .o_Data_s2f(oData), .o_RdValid(oRdValid), .o_Ready(oReady),
        .o_CS_N(oCsN), .o_OE_N(oOeN), .o_WE_N(oWeN), .o_BE_N(oBeN),
        .o_Addr(oAddr), .io_IO(sramBus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural async SRAM: drives enabled lanes while selected with OE low, stores enabled lanes while WE is low.
    logic [DATA_W-1:0] sramMem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] sramOut = '0;

    for (genvar b = 0; b < BE_W; b++) begin : g_lane
        assign sramBus[b*8 +: 8] = (!oCsN && !oOeN && oWeN && !oBeN[b]) ? sramOut[b*8 +: 8] : 8'hzz;
    end

    always @(negedge clk) begin
        logic [DATA_W-1:0] w;
        if (!oCsN && !oWeN) begin
            w = sramMem.exists(oAddr) ? sramMem[oAddr] : '0;
            for (int b = 0; b < BE_W; b++) begin
                if (!oBeN[b]) w[b*8 +: 8] = sramBus[b*8 +: 8];
            end
            sramMem[oAddr] = w;
        end
        sramOut = sramMem.exists(oAddr) ? sramMem[oAddr] : '0;
    end

    typedef struct {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] expRd;
        logic [DATA_W-1:0] expMem;
    } vec_t;

    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } exp_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [DATA_W-1:0] laneMaskOf(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        for (int b = 0; b < BE_W; b++) m[b*8 +: 8] = {8{be[b]}};
        return m;
    endfunction

    // Issue one access from idle and observe the pins for eight cycles after the accept edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        int weLow, oeLow, csLow, busCnt, validAt, readyAt, lanesBad;
        logic [DATA_W-1:0] rd;
        weLow = 0; oeLow = 0; csLow = 0; busCnt = 0; validAt = -1; readyAt = -1; lanesBad = 0; rd = '0;
        @(negedge clk);
        iBegin = 1'b1; iWrite = v.write; iAddr = v.addr; iBE = v.be; iData = v.data;
        @(negedge clk);
        iBegin = 1'b0; iAddr = ~v.addr; iBE = ~v.be; iData = ~v.data;
        for (int c = 1; c <= 8; c++) begin
            if (!oWeN) weLow++;
            if (!oOeN) oeLow++;
            if (!oCsN) begin
                csLow++;
                if (oBeN !== ~v.be || oAddr !== v.addr) lanesBad++;
            end
            if (!oCsN && oOeN && sramBus === v.data) busCnt++;
            if (oRdValid && validAt < 0) begin
                validAt = c;
                rd = oData;
            end
            if (oReady && readyAt < 0) readyAt = c;
            @(negedge clk);
        end
        checkOutput($sformatf("v%0d lanes/addr during access", idx), lanesBad, 0);
        checkOutput($sformatf("v%0d addr held in idle", idx), oAddr, v.addr);
        if (v.write) begin
            checkOutput($sformatf("v%0d WE_N low cycles", idx), weLow, WR_WAIT);
            checkOutput($sformatf("v%0d bus driven cycles", idx), busCnt, WR_WAIT + 1);
            checkOutput($sformatf("v%0d CS_N low cycles", idx), csLow, WR_WAIT + 1);
            checkOutput($sformatf("v%0d OE_N low cycles", idx), oeLow, 0);
            checkOutput($sformatf("v%0d ready cycle", idx), readyAt, WR_WAIT + 1);
            checkOutput($sformatf("v%0d no rdvalid", idx), validAt, -1);
            checkOutput($sformatf("v%0d memory", idx), sramMem[v.addr], v.expMem);
        end else begin
            checkOutput($sformatf("v%0d OE_N low cycles", idx), oeLow, RD_WAIT + 1);
            checkOutput($sformatf("v%0d WE_N low cycles", idx), weLow, 0);
            checkOutput($sformatf("v%0d CS_N low cycles", idx), csLow, RD_WAIT + 1);
            checkOutput($sformatf("v%0d ready cycle", idx), readyAt, RD_WAIT + 1);
            checkOutput($sformatf("v%0d rdvalid cycle", idx), validAt, RD_WAIT + 2);
            checkOutput($sformatf("v%0d read data", idx), rd, v.expRd);
        end
    endtask

    initial begin
        vec_t vecs [11];
        vec_t seq [6];
        logic [ADDR_W-1:0] pool [16];
        logic [DATA_W-1:0] refMem [logic [ADDR_W-1:0]];
        exp_t expQ [$];
        exp_t e;
        logic [DATA_W-1:0] w;
        int idx, reads, window, csHigh, overlap, busy, cyc, extra;
        logic rdy, inEnd, lastRead, expValid;

        vecs[0]  = '{1'b1, 19'h12345, 2'b11, 16'hBEEF, 16'h0000, 16'hBEEF};
        vecs[1]  = '{1'b0, 19'h12345, 2'b11, 16'h0000, 16'hBEEF, 16'h0000};
        vecs[2]  = '{1'b0, 19'h00010, 2'b11, 16'h0000, 16'hA5C3, 16'h0000};
        vecs[3]  = '{1'b1, 19'h00020, 2'b11, 16'hFFFF, 16'h0000, 16'hFFFF};
        vecs[4]  = '{1'b1, 19'h00020, 2'b01, 16'h1234, 16'h0000, 16'hFF34};
        vecs[5]  = '{1'b0, 19'h00020, 2'b10, 16'h0000, 16'hFF00, 16'h0000};
        vecs[6]  = '{1'b0, 19'h00020, 2'b01, 16'h0000, 16'h0034, 16'h0000};
        vecs[7]  = '{1'b0, 19'h00020, 2'b11, 16'h0000, 16'hFF34, 16'h0000};
        vecs[8]  = '{1'b1, 19'h7FFFF, 2'b10, 16'hAB77, 16'h0000, 16'hAB00};
        vecs[9]  = '{1'b0, 19'h7FFFF, 2'b11, 16'h0000, 16'hAB00, 16'h0000};
        vecs[10] = '{1'b0, 19'h00010, 2'b00, 16'h0000, 16'h0000, 16'h0000};

        seq[0] = '{1'b1, 19'h00100, 2'b11, 16'h1357, 16'h0000, 16'h0000};
        seq[1] = '{1'b0, 19'h00100, 2'b11, 16'h0000, 16'h1357, 16'h0000};
        seq[2] = '{1'b1, 19'h00200, 2'b11, 16'h2468, 16'h0000, 16'h0000};
        seq[3] = '{1'b0, 19'h00200, 2'b11, 16'h0000, 16'h2468, 16'h0000};
        seq[4] = '{1'b1, 19'h40300, 2'b11, 16'h9ABC, 16'h0000, 16'h0000};
        seq[5] = '{1'b0, 19'h40300, 2'b11, 16'h0000, 16'h9ABC, 16'h0000};

        sramMem[19'h00010] = 16'hA5C3;
        sramMem[19'h12345] = 16'h0000;
        sramMem[19'h00020] = 16'h0000;
        sramMem[19'h7FFFF] = 16'h0000;

        iReset = 1'b1; iBegin = 1'b0; iWrite = 1'b0; iAddr = '0; iBE = '0; iData = '0;

        // Reset state, then a write aborted by a three-cycle reset.
        repeat (3) @(negedge clk);
        checkOutput("ready low in reset", oReady, 0);
        iReset = 1'b0;
        @(negedge clk);
        checkOutput("reset ready", oReady, 1);
        checkOutput("reset strobes CS/OE/WE", {oCsN, oOeN, oWeN}, 3'b111);
        checkOutput("reset BE_N", oBeN, 2'b11);
        checkOutput("reset addr", oAddr, 0);
        checkOutput("reset data", oData, 0);
        checkOutput("reset rdvalid", oRdValid, 0);

        iBegin = 1'b1; iWrite = 1'b1; iAddr = 19'h55555; iBE = 2'b11; iData = 16'h1111;
        @(negedge clk);
        iBegin = 1'b0;
        checkOutput("mid-write WE_N low", oWeN, 0);
        iReset = 1'b1;
        @(negedge clk);
        checkOutput("abort strobes CS/OE/WE", {oCsN, oOeN, oWeN}, 3'b111);
        checkOutput("abort ready", oReady, 0);
        checkOutput("abort bus released", (sramBus === 16'h1111), 0);
        repeat (2) begin
            @(negedge clk);
            checkOutput("ready held low in reset", oReady, 0);
        end
        iReset = 1'b0;
        @(negedge clk);
        checkOutput("ready after release", oReady, 1);

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Back-to-back alternating write/read with Begin held.
        idx = 0; reads = 0; window = 0; csHigh = 0; overlap = 0;
        @(negedge clk);
        iBegin = 1'b1; iWrite = seq[0].write; iAddr = seq[0].addr; iBE = seq[0].be; iData = seq[0].data;
        rdy = oReady;
        for (int c = 0; c < 80 && reads < 3; c++) begin
            @(negedge clk);
            if (rdy && iBegin) idx++;
            if (!oOeN && !oWeN) overlap++;
            if (!(oRdValid && reads == 2)) begin
                window++;
                if (oCsN) csHigh++;
            end
            if (oRdValid) begin
                checkOutput($sformatf("b2b read %0d data", reads), oData, seq[2*reads+1].expRd);
                if (reads == 0) begin
                    if (TURN != 0)
                        checkOutput("turnaround dead cycle CS/OE/WE/Ready", {oCsN, oOeN, oWeN, oReady}, 4'b1110);
                    else
                        checkOutput("no turnaround WE_N low", oWeN, 0);
                end
                reads++;
            end
            if (idx < 6) begin
                iBegin = 1'b1; iWrite = seq[idx].write; iAddr = seq[idx].addr; iBE = seq[idx].be; iData = seq[idx].data;
            end else begin
                iBegin = 1'b0;
            end
            rdy = oReady;
        end
        iBegin = 1'b0;
        checkOutput("b2b reads completed", reads, 3);
        checkOutput("b2b OE/WE overlap", overlap, 0);
        checkOutput("b2b CS_N high cycles", csHigh, 2 * TURN);
        checkOutput("b2b total cycles", window, 3 * (WR_WAIT + 1) + 3 * (RD_WAIT + 1) + 2 * TURN);

        // Randomized traffic against a transaction-level timing and memory model.
        repeat (4) @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            pool[k] = ADDR_W'($urandom);
            w = DATA_W'($urandom);
            sramMem[pool[k]] = w;
            refMem[pool[k]] = w;
        end
        busy = 0; inEnd = 1'b0; lastRead = 1'b0; cyc = 0;
        for (int n = 0; n < 1510; n++) begin
            @(posedge clk);
            cyc++;
            if (iBegin && busy == 0) begin
                if (iWrite) begin
                    extra = (TURN != 0 && inEnd && lastRead) ? 1 : 0;
                    w = refMem[iAddr];
                    for (int b = 0; b < BE_W; b++) begin
                        if (iBE[b]) w[b*8 +: 8] = iData[b*8 +: 8];
                    end
                    refMem[iAddr] = w;
                    busy = WR_WAIT + extra;
                end else begin
                    e.due = cyc + RD_WAIT + 1;
                    e.data = refMem[iAddr] & laneMaskOf(iBE);
                    expQ.push_back(e);
                    busy = RD_WAIT;
                end
                lastRead = !iWrite;
                inEnd = 1'b0;
            end else if (busy > 0) begin
                busy--;
                inEnd = (busy == 0);
            end else begin
                inEnd = 1'b0;
            end
            @(negedge clk);
            checkOutput("rand ready", oReady, busy == 0);
            expValid = (expQ.size() > 0) && (expQ[0].due == cyc);
            checkOutput("rand rdvalid", oRdValid, expValid);
            if (expValid) begin
                checkOutput("rand read data", oData, expQ[0].data);
                void'(expQ.pop_front());
            end
            checkOutput("rand OE/WE overlap", (!oOeN && !oWeN), 0);
            iBegin = (n < 1500) && ($urandom_range(0, 3) != 0);
            iWrite = 1'($urandom_range(0, 1));
            iAddr = pool[$urandom_range(0, 15)];
            iBE = BE_W'($urandom);
            iData = DATA_W'($urandom);
        end
        checkOutput("rand reads drained", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
